// File: rtl/key_debounce_array_if.sv
// Raw button levels in, conditioned level and event pulses out.
// The master side drives the keys; the slave side is the conditioner.
interface key_debounce_array_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long, key_repeat
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long, key_repeat
    );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel push-button conditioner: synchroniser, debounce filter,
// press/release events, long-press detection and auto-repeat on a shared 1 ms tick.
module key_debounce_array #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned N_KEYS      = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input logic                 clk,
    input logic                 rst_n,
    key_debounce_array_if.slave kb
);
    localparam int unsigned PRESC = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned DW    = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HW    = $clog2(LONG_MS + 1);
    localparam int unsigned RW    = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] LONG_LAST  = HW'(LONG_MS - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam logic [N_KEYS-1:0] REL_LVL = ACTIVE_LOW ? '1 : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic [PW-1:0]     presc_cnt;
    logic              tick;
    logic [N_KEYS-1:0] sync1, sync2, lvl;
    logic [N_KEYS-1:0] level, acc_press, acc_rel;
    logic [N_KEYS-1:0] press_q, release_q, long_q, repeat_q;
    logic [DW-1:0]     db_cnt   [N_KEYS];
    logic [HW-1:0]     hold_cnt [N_KEYS];
    logic [RW-1:0]     rep_cnt  [N_KEYS];
    logic [1:0]        state    [N_KEYS];

    assign tick = (presc_cnt == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= kb.key_in;
            sync2 <= sync1;
        end
    end

    assign lvl = sync2 ^ REL_LVL;

    always_comb begin
        acc_press = '0;
        acc_rel   = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (tick && (lvl[i] != level[i]) && (db_cnt[i] == DB_LAST)) begin
                acc_press[i] = lvl[i];
                acc_rel[i]   = ~lvl[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level     <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
                rep_cnt[i]  <= '0;
                state[i]    <= ST_IDLE;
            end
        end else begin
            press_q   <= acc_press;
            release_q <= acc_rel;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                if (lvl[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end

                // A release accepted on a threshold tick takes priority over long/repeat.
                case (state[i])
                    ST_IDLE: begin
                        if (acc_press[i]) begin
                            hold_cnt[i] <= '0;
                            state[i]    <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (acc_rel[i]) begin
                            state[i] <= ST_IDLE;
                        end else if (tick) begin
                            hold_cnt[i] <= hold_cnt[i] + HW'(1);
                            if (hold_cnt[i] == LONG_LAST) begin
                                long_q[i]  <= 1'b1;
                                rep_cnt[i] <= '0;
                                state[i]   <= ST_LONG;
                            end
                        end
                    end
                    ST_LONG: begin
                        if (acc_rel[i]) begin
                            state[i] <= ST_IDLE;
                        end else if ((REPEAT_MS > 0) && tick) begin
                            if (rep_cnt[i] == REP_LAST) begin
                                repeat_q[i] <= 1'b1;
                                rep_cnt[i]  <= '0;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + RW'(1);
                            end
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign kb.key_level   = level;
    assign kb.key_press   = press_q;
    assign kb.key_release = release_q;
    assign kb.key_long    = long_q;
    assign kb.key_repeat  = repeat_q;
endmodule

// File: tb/tb_key_debounce_array.sv
// Directed scenarios plus random key activity on an active-high and an active-low
// instance, compared every cycle against a tick-counting reference model.
module tb_key_debounce_array;
    localparam int NK    = 2;
    localparam int PRESC = 10;
    localparam int DEB   = 3;
    localparam int LONG  = 10;
    localparam int REP   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NK-1:0] k0, k1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    key_debounce_array_if #(.N_KEYS(NK)) bus0 ();
    key_debounce_array_if #(.N_KEYS(NK)) bus1 ();
    assign bus0.key_in = k0;
    assign bus1.key_in = k1;

    key_debounce_array #(
        .CLK_FREQ(10_000), .N_KEYS(NK), .DEBOUNCE_MS(DEB),
        .LONG_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(1'b0)
    ) dut (.clk(clk), .rst_n(rst_n), .kb(bus0));

    key_debounce_array #(
        .CLK_FREQ(10_000), .N_KEYS(NK), .DEBOUNCE_MS(DEB),
        .LONG_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(1'b1)
    ) dut_al (.clk(clk), .rst_n(rst_n), .kb(bus1));

    // Reference model: ticks counted since reset, mismatch ticks, ticks held since press.
    bit pol [2] = '{1'b0, 1'b1};
    bit h1 [2][NK];
    bit h2 [2][NK];
    int mism [2][NK];
    int held [2][NK];
    int edges = 0;
    logic [NK-1:0] e_lvl [2], e_prs [2], e_rel [2], e_lng [2], e_rpt [2];

    int np [NK], nr [NK], nl [NK], nrep [NK];
    int tp [NK], tl [NK], trep [NK];
    int np1 = 0;
    bit both_prs, rel01;

    task automatic model_step();
        bit tick, lv, acc;
        logic [NK-1:0] kin [2];
        kin[0] = k0;
        kin[1] = k1;
        if (!rst_n) begin
            edges = 0;
            for (int i = 0; i < 2; i++) begin
                e_lvl[i] = '0; e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0; e_rpt[i] = '0;
                for (int c = 0; c < NK; c++) begin
                    h1[i][c] = pol[i]; h2[i][c] = pol[i];
                    mism[i][c] = 0; held[i][c] = 0;
                end
            end
            return;
        end
        tick = ((edges % PRESC) == PRESC - 1);
        edges++;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NK; c++) begin
                lv = h2[i][c] ^ pol[i];
                h2[i][c] = h1[i][c];
                h1[i][c] = kin[i][c];
                e_prs[i][c] = 1'b0; e_rel[i][c] = 1'b0;
                e_lng[i][c] = 1'b0; e_rpt[i][c] = 1'b0;
                acc = 1'b0;
                if (lv == e_lvl[i][c]) begin
                    mism[i][c] = 0;
                end else if (tick) begin
                    mism[i][c]++;
                    if (mism[i][c] == DEB) begin
                        acc = 1'b1;
                        mism[i][c] = 0;
                        e_lvl[i][c] = lv;
                        if (lv) begin
                            e_prs[i][c] = 1'b1;
                            held[i][c] = 0;
                        end else begin
                            e_rel[i][c] = 1'b1;
                        end
                    end
                end
                if (!acc && e_lvl[i][c] && tick) begin
                    held[i][c]++;
                    if (held[i][c] == LONG)
                        e_lng[i][c] = 1'b1;
                    else if (REP > 0 && held[i][c] > LONG && ((held[i][c] - LONG) % REP) == 0)
                        e_rpt[i][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d (cycle %0d)", tag, obs, lo, hi, cyc);
        end
    endtask

    task automatic compare();
        chk("level0",   bus0.key_level,   e_lvl[0]);
        chk("press0",   bus0.key_press,   e_prs[0]);
        chk("release0", bus0.key_release, e_rel[0]);
        chk("long0",    bus0.key_long,    e_lng[0]);
        chk("repeat0",  bus0.key_repeat,  e_rpt[0]);
        chk("level1",   bus1.key_level,   e_lvl[1]);
        chk("press1",   bus1.key_press,   e_prs[1]);
        chk("release1", bus1.key_release, e_rel[1]);
        chk("long1",    bus1.key_long,    e_lng[1]);
        chk("repeat1",  bus1.key_repeat,  e_rpt[1]);
        for (int c = 0; c < NK; c++) begin
            if (bus0.key_press[c] === 1'b1)   begin np[c]++;   tp[c] = cyc;   end
            if (bus0.key_release[c] === 1'b1) nr[c]++;
            if (bus0.key_long[c] === 1'b1)    begin nl[c]++;   tl[c] = cyc;   end
            if (bus0.key_repeat[c] === 1'b1)  begin nrep[c]++; trep[c] = cyc; end
        end
        if (bus0.key_press === 2'b11)   both_prs = 1'b1;
        if (bus0.key_release === 2'b01) rel01 = 1'b1;
        if (bus1.key_press !== 2'b00)   np1++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NK; c++) begin
            np[c] = 0; nr[c] = 0; nl[c] = 0; nrep[c] = 0;
            tp[c] = 0; tl[c] = 0; trep[c] = 0;
        end
        both_prs = 1'b0;
        rel01 = 1'b0;
    endtask

    initial begin
        int t0;
        int idx;
        k0 = '0;
        k1 = '1;
        rst_n = 1'b0;
        clear_obs();
        repeat (3) step();
        chk("rst_level", bus0.key_level, '0);
        chk("rst_press", bus0.key_press, '0);
        rst_n = 1'b1;
        repeat (20) step();

        // Clean press and release on key 0
        clear_obs();
        k0[0] = 1'b1; t0 = cyc;
        repeat (60) step();
        chk_int("s1_press_cnt", np[0], 1);
        chk_range("s1_press_lat", tp[0] - t0, 23, 32);
        chk("s1_level", bus0.key_level, 2'b01);
        k0[0] = 1'b0;
        repeat (45) step();
        chk_int("s1_release_cnt", nr[0], 1);
        chk_int("s1_long_cnt", nl[0], 0);

        // Bounce every 7 clk, then settle high
        clear_obs();
        for (int j = 0; j < 100; j++) begin
            if (j % 7 == 0) k0[0] = ~k0[0];
            step();
        end
        chk_int("s2_bounce_press", np[0], 0);
        chk_int("s2_bounce_release", nr[0], 0);
        k0[0] = 1'b1; t0 = cyc;
        repeat (40) step();
        chk_int("s2_press_cnt", np[0], 1);
        chk_range("s2_press_lat", tp[0] - t0, 0, 32);
        k0[0] = 1'b0;
        repeat (45) step();

        // Long press with auto-repeat on key 1
        clear_obs();
        k0[1] = 1'b1;
        repeat (200) step();
        k0[1] = 1'b0;
        repeat (45) step();
        chk_int("s3_press_cnt", np[1], 1);
        chk_int("s3_long_cnt", nl[1], 1);
        chk_int("s3_long_delay", tl[1] - tp[1], 100);
        chk_int("s3_repeat_cnt", nrep[1], 2);
        chk_int("s3_last_repeat", trep[1] - tl[1], 80);
        chk_int("s3_release_cnt", nr[1], 1);

        // Independent channels
        clear_obs();
        k0 = 2'b11;
        repeat (40) step();
        chk_int("s4_both_press", int'(both_prs), 1);
        k0[0] = 1'b0;
        repeat (40) step();
        chk_int("s4_release_01", int'(rel01), 1);
        repeat (60) step();
        chk_int("s4_long_key1", nl[1], 1);
        chk_int("s4_long_key0", nl[0], 0);
        k0[1] = 1'b0;
        repeat (45) step();

        // Reset during long hold, key stays pressed
        clear_obs();
        k0[0] = 1'b1;
        repeat (150) step();
        chk_int("s5_long_cnt", nl[0], 1);
        rst_n = 1'b0;
        step();
        chk("s5_rst_level",   bus0.key_level,   '0);
        chk("s5_rst_release", bus0.key_release, '0);
        chk("s5_rst_repeat",  bus0.key_repeat,  '0);
        step();
        step();
        rst_n = 1'b1;
        np[0] = 0;
        repeat (40) step();
        chk_int("s5_no_release", nr[0], 0);
        chk_int("s5_repress", np[0], 1);
        k0[0] = 1'b0;
        repeat (45) step();

        // Active-low instance: held released since start, then press key 0
        chk_int("s6_no_false_press", np1, 0);
        k1[0] = 1'b0;
        repeat (40) step();
        chk_int("s6_press_cnt", np1, 1);
        chk("s6_level", bus1.key_level, 2'b01);
        k1[0] = 1'b1;
        repeat (45) step();

        // Random activity: fast bouncing first, then slow holds that reach long/repeat
        for (int j = 0; j < 1600; j++) begin
            int unsigned rate;
            rate = (j < 700) ? 6 : 150;
            if ($urandom_range(rate - 1) == 0) begin
                idx = int'($urandom_range(NK - 1));
                k0[idx] = ~k0[idx];
            end
            if ($urandom_range(rate - 1) == 0) begin
                idx = int'($urandom_range(NK - 1));
                k1[idx] = ~k1[idx];
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
